// File: rtl/cpu.sv
// cpu: single-cycle RV32I core built from alu, rf and dmem instances.
// Define CPU_UPPER_IMM_EN to add lui/auipc; otherwise both execute as NOPs.
module alu (
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   input  logic [3:0]  i_op,
   output logic [31:0] o_result
);
   logic [4:0] sh;
   assign sh = i_op_b[4:0];
   always_comb begin
      case (i_op[2:0])
         3'b000: o_result = i_op[3] ? i_op_a - i_op_b : i_op_a + i_op_b;
         3'b001: o_result = i_op_a << sh;
         3'b010: o_result = {31'b0, $signed(i_op_a) < $signed(i_op_b)};
         3'b011: o_result = {31'b0, i_op_a < i_op_b};
         3'b100: o_result = i_op_a ^ i_op_b;
         3'b101: o_result = i_op[3] ? $unsigned($signed(i_op_a) >>> sh) : i_op_a >> sh;
         3'b110: o_result = i_op_a | i_op_b;
         default: o_result = i_op_a & i_op_b;
      endcase
   end
endmodule

module rf (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [4:0]  i_rd,
   input  logic        i_we,
   input  logic [31:0] i_wd,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2
);
   logic [31:0] q [0:30];
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) for (int i = 0; i < 31; i++) q[i] <= '0;
      else if (i_we && i_rd != 5'd0) q[i_rd - 5'd1] <= i_wd;
   assign o_rd1 = i_rs1 == 5'd0 ? '0 : q[i_rs1 - 5'd1];
   assign o_rd2 = i_rs2 == 5'd0 ? '0 : q[i_rs2 - 5'd1];
endmodule

module dmem (
   input  logic        i_clk,
   input  logic [10:0] i_addr,
   input  logic [31:0] i_write_data,
   input  logic [31:0] i_write_mask,
   input  logic        i_write_enable,
   output logic [31:0] o_read_data
);
   logic [31:0] q [0:2047];
   always_ff @(posedge i_clk)
      if (i_write_enable) q[i_addr] <= (q[i_addr] & ~i_write_mask) | (i_write_data & i_write_mask);
   assign o_read_data = q[i_addr];
endmodule

module cpu (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_inst,
   output logic [31:0] o_pc
);
   logic [31:0] pc, next_pc, rs1_val, rs2_val, op_a, op_b, alu_result, wb_data;
   logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm;
   logic [31:0] raw_read, masked_read, shifted_read, aligned_read, mem_mask, write_data;
   logic [10:0] mem_addr;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [4:0]  lane_sh;
   logic [3:0]  alu_op;
   logic        is_op, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
   logic        reg_we, cmp_eq, cmp_lt, cmp_gt, br_taken;
   assign opcode    = i_inst[6:0];
   assign f3        = i_inst[14:12];
   assign is_op     = opcode == 7'b0110011;
   assign is_imm    = opcode == 7'b0010011;
   assign is_load   = opcode == 7'b0000011;
   assign is_store  = opcode == 7'b0100011;
   assign is_branch = opcode == 7'b1100011;
   assign is_jal    = opcode == 7'b1101111;
   assign is_jalr   = opcode == 7'b1100111;
`ifdef CPU_UPPER_IMM_EN
   assign is_lui    = opcode == 7'b0110111;
   assign is_auipc  = opcode == 7'b0010111;
`else
   assign is_lui    = 1'b0;
   assign is_auipc  = 1'b0;
`endif
   assign i_imm = {{20{i_inst[31]}}, i_inst[31:20]};
   assign s_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
   assign b_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
   assign j_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
   assign u_imm = {i_inst[31:12], 12'b0};
   rf rf (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_rs1(i_inst[19:15]), .i_rs2(i_inst[24:20]),
          .i_rd(i_inst[11:7]), .i_we(reg_we), .i_wd(wb_data), .o_rd1(rs1_val), .o_rd2(rs2_val));
   // bit 30 selects sub/sra only where the encoding reserves it for that purpose
   assign alu_op = is_op ? {i_inst[30], f3} : is_imm ? {f3 == 3'b101 && i_inst[30], f3} : 4'b0000;
   assign op_a   = (is_branch || is_jal || is_auipc) ? pc : is_lui ? '0 : rs1_val;
   assign op_b   = is_op ? rs2_val : is_store ? s_imm : is_branch ? b_imm : is_jal ? j_imm :
                   (is_lui || is_auipc) ? u_imm : i_imm;
   alu alu (.i_op_a(op_a), .i_op_b(op_b), .i_op(alu_op), .o_result(alu_result));
   assign cmp_eq   = rs1_val == rs2_val;
   assign cmp_lt   = f3[1] ? rs1_val < rs2_val : $signed(rs1_val) < $signed(rs2_val);
   assign cmp_gt   = !cmp_eq && !cmp_lt;
   assign br_taken = is_branch && f3[2:1] != 2'b01 &&
                     (f3[0] ? (f3[2] ? cmp_eq || cmp_gt : !cmp_eq) : (f3[2] ? cmp_lt : cmp_eq));
   // low address bits only pick the lane; misaligned accesses never trap
   assign mem_addr = {alu_result[10:2], 2'b00};
   assign lane_sh  = f3[1:0] == 2'b00 ? {alu_result[1:0], 3'b000} :
                     f3[1:0] == 2'b01 ? {alu_result[1], 4'b0000} : 5'd0;
   assign mem_mask = f3[1:0] == 2'b00 ? 32'hff << lane_sh :
                     f3[1:0] == 2'b01 ? 32'hffff << lane_sh : 32'hffff_ffff;
   assign write_data = rs2_val << lane_sh;
   dmem dmem (.i_clk(i_clk), .i_addr(mem_addr), .i_write_data(write_data), .i_write_mask(mem_mask),
              .i_write_enable(is_store && i_rst_n), .o_read_data(raw_read));
   assign masked_read  = raw_read & mem_mask;
   assign shifted_read = masked_read >> lane_sh;
   assign aligned_read = f3[1:0] == 2'b00 ? {{24{!f3[2] && shifted_read[7]}}, shifted_read[7:0]} :
                         f3[1:0] == 2'b01 ? {{16{!f3[2] && shifted_read[15]}}, shifted_read[15:0]} :
                         shifted_read;
   assign reg_we  = is_op || is_imm || is_load || is_jal || is_jalr || is_lui || is_auipc;
   assign wb_data = is_load ? aligned_read : (is_jal || is_jalr) ? pc + 32'd4 : alu_result;
   assign next_pc = (br_taken || is_jal) ? alu_result : is_jalr ? alu_result & ~32'd1 : pc + 32'd4;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) pc <= '0;
      else pc <= next_pc;
   assign o_pc = pc;
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed RV32I cases plus a random instruction stream checked against an ISA-level model.
module tb_cpu;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [31:0] inst = 32'h0000_0013, pc;
   int checks = 0, failures = 0;
   logic [31:0] mx [0:31];
   logic [31:0] mpc;
   logic [31:0] mm [0:2047];

   cpu dut (.i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .o_pc(pc));
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                           input logic alt);
      int s;
      s = int'(b[4:0]);
      case (f3)
         3'd0: return alt ? a - b : a + b;
         3'd1: return a << s;
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: if (alt) return $signed(a) >>> s; else return a >> s;
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic model_exec(input logic [31:0] in);
      logic [31:0] a, b, ii, si, bi, ji, w, v, ea, npc, val;
      logic [2:0] f3;
      logic [4:0] rd;
      logic wr, tk;
      int idx, sh;
      a = mx[in[19:15]]; b = mx[in[24:20]]; f3 = in[14:12]; rd = in[11:7];
      ii = {{20{in[31]}}, in[31:20]};
      si = {{20{in[31]}}, in[31:25], in[11:7]};
      bi = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      ji = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      npc = mpc + 32'd4; wr = 1'b0; val = '0;
      case (in[6:0])
         7'h33: begin wr = 1'b1; val = alu_ref(a, b, f3, in[30]); end
         7'h13: begin wr = 1'b1; val = alu_ref(a, ii, f3, f3 == 3'd5 && in[30]); end
         7'h03: begin
            ea = a + ii; idx = int'(ea & 32'h7fc); w = mm[idx]; wr = 1'b1;
            if (f3[1:0] == 2'd0) begin
               v = (w >> (8 * int'(ea[1:0]))) & 32'hff;
               val = f3[2] ? v : {{24{v[7]}}, v[7:0]};
            end else if (f3[1:0] == 2'd1) begin
               v = (w >> (16 * int'(ea[1]))) & 32'hffff;
               val = f3[2] ? v : {{16{v[15]}}, v[15:0]};
            end else val = w;
         end
         7'h23: begin
            ea = a + si; idx = int'(ea & 32'h7fc);
            if (f3[1:0] == 2'd0) begin
               sh = 8 * int'(ea[1:0]);
               mm[idx] = (mm[idx] & ~(32'hff << sh)) | ((b & 32'hff) << sh);
            end else if (f3[1:0] == 2'd1) begin
               sh = 16 * int'(ea[1]);
               mm[idx] = (mm[idx] & ~(32'hffff << sh)) | ((b & 32'hffff) << sh);
            end else mm[idx] = b;
         end
         7'h63: begin
            case (f3)
               3'd0: tk = a == b;
               3'd1: tk = a != b;
               3'd4: tk = $signed(a) < $signed(b);
               3'd5: tk = $signed(a) >= $signed(b);
               3'd6: tk = a < b;
               3'd7: tk = a >= b;
               default: tk = 1'b0;
            endcase
            if (tk) npc = mpc + bi;
         end
         7'h6f: begin wr = 1'b1; val = mpc + 32'd4; npc = mpc + ji; end
         7'h67: begin wr = 1'b1; val = mpc + 32'd4; npc = (a + ii) & ~32'd1; end
`ifdef CPU_UPPER_IMM_EN
         7'h37: begin wr = 1'b1; val = {in[31:12], 12'b0}; end
         7'h17: begin wr = 1'b1; val = mpc + {in[31:12], 12'b0}; end
`endif
         default: ;
      endcase
      if (wr && rd != 5'd0) mx[rd] = val;
      mpc = npc;
   endtask

   task automatic model_reset;
      mpc = '0;
      for (int i = 0; i < 32; i++) mx[i] = '0;
   endtask

   task automatic step(input logic [31:0] in);
      inst = in;
      model_exec(in);
      @(posedge clk);
      #1;
   endtask

   task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
      step(enc_i({4'h0, v[31:24]}, 5'd0, 3'd6, r, 7'h13));
      for (int k = 2; k >= 0; k--) begin
         step(enc_i(12'd8, r, 3'd1, r, 7'h13));
         step(enc_i({4'h0, v[8*k +: 8]}, r, 3'd6, r, 7'h13));
      end
   endtask

   task automatic goto(input logic [31:0] t);
      logic [31:0] off;
      off = t - mpc;
      step(enc_j(off[20:0], 5'd0));
   endtask

   task automatic do_reset;
      rst_n = 1'b0; inst = 32'h0000_0013;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [2:0] f3, lf [0:4], bf [0:5];
      logic [4:0] rd, rs1, rs2;
      logic [11:0] imm;
      logic [12:0] bimm;
      logic alt;
      lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      f3 = 3'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      imm = 12'($urandom); alt = 1'($urandom);
      case ($urandom_range(0, 9))
         0, 1: return enc_r((f3 == 3'd0 || f3 == 3'd5) && alt ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
         2, 3: return enc_i(f3 == 3'd1 ? {7'h00, imm[4:0]} : f3 == 3'd5 ? {alt ? 7'h20 : 7'h00, imm[4:0]} : imm,
                            rs1, f3, rd, 7'h13);
         4: return enc_i(12'($urandom_range(0, 63)), 5'd0, lf[$urandom_range(0, 4)], rd, 7'h03);
         5: return enc_s(12'($urandom_range(0, 63)), rs2, 5'd0, 3'($urandom_range(0, 2)));
         6, 7: begin
            bimm = {12'($urandom), 1'b0};
            return enc_b(bimm, $urandom_range(0, 3) == 0 ? rs1 : rs2, rs1, bf[$urandom_range(0, 5)]);
         end
         8: return alt ? enc_j(21'($urandom) & ~21'd1, rd) : enc_i(imm, rs1, 3'd0, rd, 7'h67);
         default: return {25'($urandom), $urandom_range(0, 2) == 0 ? 7'h7f : alt ? 7'h37 : 7'h17};
      endcase
   endfunction

   task automatic test_reset;
      logic bad;
      rst_n = 1'b0; inst = enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
      bad = 1'b0;
      for (int i = 0; i < 31; i++) if (dut.rf.q[i] !== 32'h0) bad = 1'b1;
      checks++;
      if (bad) begin failures++; $display("FAIL reset_regs some register not cleared"); end
      rst_n = 1'b1;
      model_reset();
      step(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
      checks++;
      if (dut.rf.q[0] !== 32'd5 || pc !== 32'd4)
         begin failures++; $display("FAIL first_inst x1=%h pc=%h exp x1=5 pc=4", dut.rf.q[0], pc); end
   endtask

   task automatic test_directed;
      do_reset();
      step(enc_i(12'd3, 5'd0, 3'd0, 5'd5, 7'h13));
      step(enc_i(12'd5, 5'd0, 3'd0, 5'd24, 7'h13));
      step(32'h018280b3);
      checks++;
      if (dut.rf.q[0] !== 32'd8 || pc !== 32'd12)
         begin failures++; $display("FAIL add x1=%h pc=%h exp x1=8 pc=c", dut.rf.q[0], pc); end
      step(enc_i(12'hf8a, 5'd0, 3'd0, 5'd2, 7'h13));
      step(enc_i(12'd4, 5'd0, 3'd0, 5'd3, 7'h13));
      step(enc_r(7'h20, 5'd3, 5'd2, 3'd5, 5'd1));
      checks++;
      if (dut.rf.q[0] !== 32'hffff_fff8) begin failures++; $display("FAIL sra got=%h exp=fffffff8", dut.rf.q[0]); end
      step(enc_i(12'd12, 5'd0, 3'd0, 5'd18, 7'h13));
      step(enc_i(12'd1234, 5'd18, 3'd0, 5'd3, 7'h13));
      checks++;
      if (dut.rf.q[2] !== 32'd1246) begin failures++; $display("FAIL addi got=%0d exp=1246", dut.rf.q[2]); end
      set_reg(5'd1, 32'hdeadbeef);
      step(enc_s(12'd0, 5'd1, 5'd0, 3'd2));
      step(enc_i(12'd0, 5'd0, 3'd2, 5'd1, 7'h03));
      checks++;
      if (dut.rf.q[0] !== 32'hdeadbeef) begin failures++; $display("FAIL lw got=%h exp=deadbeef", dut.rf.q[0]); end
      step(enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'h03));
      checks++;
      if (dut.mem_mask !== 32'hff00_0000 || dut.rf.q[0] !== 32'hffff_ffde)
         begin failures++; $display("FAIL lb mask=%h x1=%h exp mask=ff000000 x1=ffffffde", dut.mem_mask, dut.rf.q[0]); end
      set_reg(5'd1, 32'hcafeb0ba);
      step(enc_s(12'd16, 5'd1, 5'd0, 3'd2));
      step(enc_i(12'd16, 5'd0, 3'd0, 5'd2, 7'h13));
      step(enc_i(12'd2, 5'd2, 3'd5, 5'd1, 7'h03));
      checks++;
      if (dut.rf.q[0] !== 32'h0000_cafe) begin failures++; $display("FAIL lhu got=%h exp=0000cafe", dut.rf.q[0]); end
      step(enc_i(12'd2, 5'd2, 3'd1, 5'd1, 7'h03));
      checks++;
      if (dut.rf.q[0] !== 32'hffff_cafe) begin failures++; $display("FAIL lh got=%h exp=ffffcafe", dut.rf.q[0]); end
      step(enc_i(12'd8, 5'd0, 3'd0, 5'd2, 7'h13));
      set_reg(5'd1, 32'hcafeb0ba);
      step(enc_s(12'd0, 5'd1, 5'd2, 3'd2));
      checks++;
      if (dut.dmem.q[8] !== 32'hcafeb0ba) begin failures++; $display("FAIL sw got=%h exp=cafeb0ba", dut.dmem.q[8]); end
      set_reg(5'd1, 32'h0000b0ba);
      step(enc_s(12'd2, 5'd1, 5'd2, 3'd1));
      checks++;
      if (dut.dmem.i_write_data !== 32'hb0ba_0000 || dut.dmem.i_write_mask !== 32'hffff_0000 ||
          dut.dmem.q[8] !== 32'hb0bab0ba)
         begin failures++; $display("FAIL sh data=%h mask=%h mem=%h exp b0ba0000 ffff0000 b0bab0ba",
                                    dut.dmem.i_write_data, dut.dmem.i_write_mask, dut.dmem.q[8]); end
      step(enc_i(12'd0, 5'd0, 3'd0, 5'd1, 7'h13));
      goto(32'h24);
      step(enc_b(13'd0, 5'd0, 5'd1, 3'd0));
      checks++;
      if (pc !== 32'h24) begin failures++; $display("FAIL beq_taken pc=%h exp=00000024", pc); end
      set_reg(5'd1, 32'h0000cafe);
      step(enc_i(12'h04c, 5'd0, 3'd0, 5'd2, 7'h13));
      goto(32'h24);
      step(enc_b(13'd0, 5'd0, 5'd1, 3'd0));
      checks++;
      if (dut.cmp_gt !== 1'b1 || pc !== 32'h28)
         begin failures++; $display("FAIL beq_not_taken gt=%b pc=%h exp gt=1 pc=00000028", dut.cmp_gt, pc); end
      step(enc_j(21'd16, 5'd1));
      checks++;
      if (dut.rf.q[0] !== 32'h2c || pc !== 32'h38)
         begin failures++; $display("FAIL jal x1=%h pc=%h exp x1=2c pc=38", dut.rf.q[0], pc); end
      step(enc_i(12'd4, 5'd2, 3'd0, 5'd1, 7'h67));
      checks++;
      if (dut.rf.q[0] !== 32'h3c || pc !== 32'h50)
         begin failures++; $display("FAIL jalr x1=%h pc=%h exp x1=3c pc=50", dut.rf.q[0], pc); end
   endtask

   task automatic test_async_reset;
      logic bad;
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (pc !== 32'h0) begin failures++; $display("FAIL async_reset_pc got=%h exp=00000000", pc); end
      bad = 1'b0;
      for (int i = 0; i < 31; i++) if (dut.rf.q[i] !== 32'h0) bad = 1'b1;
      checks++;
      if (bad) begin failures++; $display("FAIL async_reset_regs some register not cleared"); end
      inst = enc_s(12'd0, 5'd1, 5'd0, 3'd2);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut.dmem.q[0] !== 32'hdeadbeef)
         begin failures++; $display("FAIL reset_store mem0=%h exp=deadbeef", dut.dmem.q[0]); end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_nop;
      logic [31:0] p0;
      step(enc_i(12'h123, 5'd0, 3'd0, 5'd5, 7'h13));
      p0 = mpc;
      step(32'hffff_ffff);
      step({20'h12345, 5'd5, 7'h37});
      step({20'h00001, 5'd6, 7'h17});
      checks++;
      if (pc !== p0 + 32'd12) begin failures++; $display("FAIL nop_pc got=%h exp=%h", pc, p0 + 32'd12); end
      checks++;
      if (dut.rf.q[4] !== mx[5] || dut.rf.q[5] !== mx[6] || dut.rf.q[30] !== mx[31])
         begin failures++; $display("FAIL nop_regs x5=%h x6=%h exp x5=%h x6=%h", dut.rf.q[4], dut.rf.q[5], mx[5], mx[6]); end
      checks++;
      if (dut.dmem.q[0] !== 32'hdeadbeef) begin failures++; $display("FAIL nop_mem got=%h exp=deadbeef", dut.dmem.q[0]); end
   endtask

   task automatic test_random;
      int bad;
      for (int i = 1; i < 32; i++) step(enc_i(12'($urandom), 5'd0, 3'd0, 5'(i), 7'h13));
      for (int i = 1; i < 32; i += 2) step(enc_i(12'($urandom_range(0, 31)), 5'(i), 3'd1, 5'(i), 7'h13));
      for (int w = 0; w < 16; w++) step(enc_s(12'(w * 4), 5'($urandom_range(1, 31)), 5'd0, 3'd2));
      for (int n = 0; n < 600; n++) begin
         step(rand_inst());
         checks++;
         if (pc !== mpc) begin failures++; $display("FAIL rand_pc step=%0d got=%h exp=%h", n, pc, mpc); end
         bad = 0;
         for (int r = 1; r < 32; r++) if (dut.rf.q[r-1] !== mx[r]) bad = r;
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL rand_reg step=%0d x%0d got=%h exp=%h", n, bad, dut.rf.q[bad-1], mx[bad]);
         end
      end
      for (int w = 0; w < 64; w += 4) begin
         checks++;
         if (dut.dmem.q[w] !== mm[w]) begin failures++; $display("FAIL rand_mem addr=%0d got=%h exp=%h", w, dut.dmem.q[w], mm[w]); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_directed();
      test_async_reset();
      test_nop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
